// File: rtl/toggle_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_rr_scheduler
//  Purpose  : Round-robin owner of a shared toggle cell's enable; runs N-cycle
//             bursts per requester and checks the cell's final parity.
//  Revision : 1.0  initial release
// ============================================================================
module toggle_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*CNT_W-1:0]   req_cnt,
   input  logic                    err_clr,
   input  logic                    q_in,
   output logic [NREQ-1:0]         gnt,
   output logic                    en,
   output logic                    busy,
   output logic [IDX_W-1:0]        owner,
   output logic                    done,
   output logic                    err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NREQ - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_rem;
   logic               r_expect;

   logic               w_any;
   logic [IDX_W-1:0]   w_win;
   logic [CNT_W-1:0]   w_win_cnt;
   logic [NREQ-1:0]    w_sh_req;
   int                 w_idx;

   // Scan from the highest offset down so the candidate closest to r_ptr
   // is the last one written and therefore wins.
   always_comb begin
      w_any     = 1'b0;
      w_win     = '0;
      w_win_cnt = '0;
      w_sh_req  = '0;
      w_idx     = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_idx    = (int'(r_ptr) + i) % NREQ;
         w_sh_req = req >> w_idx;
         if (w_sh_req[0]) begin
            w_any     = 1'b1;
            w_win     = IDX_W'(w_idx);
            w_win_cnt = CNT_W'(req_cnt >> (w_idx * CNT_W));
         end
      end
   end

   assign en = (r_state == RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_rem    <= '0;
         r_expect <= 1'b0;
         gnt      <= '0;
         busy     <= 1'b0;
         owner    <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         if (err_clr) begin
            err <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  gnt      <= NREQ'(1) << w_win;
                  owner    <= w_win;
                  busy     <= 1'b1;
                  r_rem    <= w_win_cnt;
                  // Final q must differ from the start value by the burst parity.
                  r_expect <= q_in ^ w_win_cnt[0];
                  r_ptr    <= (w_win == c_last_idx) ? '0 : w_win + 1'b1;
                  r_state  <= (w_win_cnt != '0) ? RUN : CHECK;
               end
            end
            RUN: begin
               r_rem <= r_rem - 1'b1;
               if (r_rem == CNT_W'(1)) begin
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
               if (q_in != r_expect) begin
                  err <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_toggle_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_rr_scheduler
//  Purpose  : Directed bench for toggle_rr_scheduler with a burst-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_toggle_rr_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] req_cnt = '0;
   logic        err_clr = 1'b0;
   logic        q_in;
   logic [3:0]  gnt;
   logic        en;
   logic        busy;
   logic [1:0]  owner;
   logic        done;
   logic        err;

   logic        stuck = 1'b0;
   logic        cell_q = 1'b0;
   logic        cell_load = 1'b0;
   logic        cell_val = 1'b0;

   int errors = 0;
   int checks = 0;

   toggle_rr_scheduler #(.NREQ(4), .CNT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .req_cnt (req_cnt),
      .err_clr (err_clr),
      .q_in    (q_in),
      .gnt     (gnt),
      .en      (en),
      .busy    (busy),
      .owner   (owner),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Shared toggle cell, with a stuck-at-0 fault option on its output.
   assign q_in = stuck ? 1'b0 : cell_q;
   always @(posedge clk) begin
      if (cell_load) cell_q <= cell_val;
      else if (en)   cell_q <= ~cell_q;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- burst-level model ----------------
   typedef struct packed {
      logic [3:0] g;
      logic       e;
      logic       b;
      logic       d;
      logic       c;
   } rec_t;

   function automatic rec_t mk(logic [3:0] g, logic e, logic b, logic d, logic c);
      rec_t r;
      r.g = g; r.e = e; r.b = b; r.d = d; r.c = c;
      return r;
   endfunction

   rec_t plan[$];
   rec_t m_cur   = '0;
   int   m_owner = 0;
   int   m_ptr   = 0;
   int   m_n     = 0;
   logic m_qstart = 1'b0;
   logic m_err   = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         plan.delete();
         m_cur   = '0;
         m_owner = 0;
         m_ptr   = 0;
         m_err   = 1'b0;
      end else begin
         if (plan.size() == 0 && req != 4'b0000) begin
            int w;
            w = -1;
            for (int k = 0; k < 4; k++)
               if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            m_n      = int'((req_cnt >> (w * 4)) & 16'h000F);
            m_qstart = q_in;
            m_owner  = w;
            m_ptr    = (w + 1) % 4;
            // grant cycle, remaining enable cycles, check cycle, done cycle
            plan.push_back(mk(4'(1 << w), m_n > 0, 1'b1, 1'b0, 1'b0));
            for (int j = 1; j < m_n; j++) plan.push_back(mk(4'b0, 1'b1, 1'b1, 1'b0, 1'b0));
            if (m_n > 0) plan.push_back(mk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            plan.push_back(mk(4'b0, 1'b0, 1'b0, 1'b1, 1'b1));
         end
         if (plan.size() > 0) m_cur = plan.pop_front();
         else                 m_cur = '0;
         if (m_cur.c && (q_in != (m_qstart ^ m_n[0]))) m_err = 1'b1;
         else if (err_clr)                                m_err = 1'b0;
      end
   end

   always @(negedge clk) begin
      check("cmp_gnt",   int'(gnt),   int'(m_cur.g));
      check("cmp_en",    int'(en),    int'(m_cur.e));
      check("cmp_busy",  int'(busy),  int'(m_cur.b));
      check("cmp_done",  int'(done),  int'(m_cur.d));
      check("cmp_owner", int'(owner), m_owner);
      check("cmp_err",   int'(err),   int'(m_err));
   end

   // ---------------- event monitor ----------------
   int en_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int glog[$];
   int gcyc[$];

   function automatic int oh_idx(logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (en)   en_cnt++;
      if (done) done_cnt++;
      if (gnt != 4'b0000) begin
         glog.push_back(oh_idx(gnt));
         gcyc.push_back(cyc);
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         tick();
         if (gnt != 4'b0000) break;
      end
      check(name, int'(gnt != 4'b0000), 1);
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         tick();
         if (done) break;
      end
      check(name, int'(done), 1);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      int e0;
      int base;
      int d0;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};

      #2;
      check("rst_gnt",   int'(gnt),   0);
      check("rst_en",    int'(en),    0);
      check("rst_busy",  int'(busy),  0);
      check("rst_owner", int'(owner), 0);
      check("rst_done",  int'(done),  0);
      check("rst_err",   int'(err),   0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // 1: single burst of 3 from requester 0, cell starts at 0
      req_cnt = 16'h0003;
      e0 = en_cnt;
      req = 4'b0001;
      wait_gnt("t1_gnt_wait", 5);
      check("t1_gnt_vec", int'(gnt), 1);
      req = 4'b0000;
      wait_done("t1_done_wait", 10);
      check("t1_en_cycles", en_cnt - e0, 3);
      check("t1_q_end",     int'(cell_q), 1);
      check("t1_owner",     int'(owner),  0);
      check("t1_err",       int'(err),    0);

      // 2: all requesting with length 1, fresh pointer
      pulse_reset();
      req_cnt = 16'h1111;
      base = glog.size();
      req = 4'b1111;
      for (int k = 0; k < 40; k++) begin
         if (glog.size() >= base + 5) break;
         tick();
      end
      req = 4'b0000;
      check("t2_grant_count", glog.size() - base, 5);
      if (glog.size() >= base + 5) begin
         for (int k = 0; k < 5; k++) check("t2_order", glog[base + k], exp_order[k]);
         for (int k = 0; k < 4; k++) check("t2_period", gcyc[base + k + 1] - gcyc[base + k], 3);
      end
      wait_done("t2_done_wait", 10);

      // 3: zero-length burst on requester 2
      tick();
      req_cnt = 16'h5055;
      e0 = en_cnt;
      req = 4'b0100;
      wait_gnt("t3_gnt_wait", 5);
      check("t3_gnt_vec", int'(gnt), 4);
      req = 4'b0000;
      wait_done("t3_done_wait", 5);
      check("t3_en_cycles", en_cnt - e0, 0);
      check("t3_err",       int'(err), 0);

      // 4: stuck cell, clear, then clear colliding with a new mismatch
      tick();
      stuck = 1'b1;
      req_cnt = 16'h0010;
      req = 4'b0010;
      wait_gnt("t4_gnt_wait", 5);
      req = 4'b0000;
      wait_done("t4_done_wait", 5);
      check("t4_err_set", int'(err), 1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t4_err_clr", int'(err), 0);
      req = 4'b0010;
      err_clr = 1'b1;
      wait_gnt("t4b_gnt_wait", 5);
      req = 4'b0000;
      wait_done("t4b_done_wait", 5);
      check("t4_set_wins", int'(err), 1);
      tick();
      check("t4_clr_after", int'(err), 0);
      err_clr = 1'b0;
      stuck = 1'b0;

      // 5: maximum burst from q=1, then reset mid-burst
      cell_val = 1'b1;
      cell_load = 1'b1;
      tick();
      cell_load = 1'b0;
      req_cnt = 16'hF000;
      e0 = en_cnt;
      req = 4'b1000;
      wait_gnt("t5_gnt_wait", 5);
      check("t5_gnt_vec", int'(gnt), 8);
      req = 4'b0000;
      wait_done("t5_done_wait", 25);
      check("t5_en_cycles", en_cnt - e0, 15);
      check("t5_q_end",     int'(cell_q), 0);
      check("t5_err",       int'(err), 0);

      req_cnt = 16'h000F;
      req = 4'b0001;
      wait_gnt("t5b_gnt_wait", 5);
      req = 4'b0000;
      for (int k = 0; k < 4; k++) tick();
      check("t5_en_midrun", int'(en), 1);
      d0 = done_cnt;
      reset = 1'b0;
      #1;
      check("t5_rst_en",   int'(en),   0);
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_gnt",  int'(gnt),  0);
      check("t5_rst_done", int'(done), 0);
      tick();
      tick();
      reset = 1'b1;
      req_cnt = 16'h2020;
      req = 4'b1010;
      wait_gnt("t5c_gnt_wait", 5);
      check("t5_first_gnt", int'(gnt),   2);
      check("t5_owner",     int'(owner), 1);
      check("t5_no_done",   done_cnt - d0, 0);
      req = 4'b0000;
      wait_done("t5c_done_wait", 10);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
